// File: rtl/mstream_pkg.sv
// mstream_pkg: state encoding and default widths shared by the matrix stream transmitter
package mstream_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_e;

    localparam int MSTREAM_DATA_WIDTH = 32;
    localparam int MSTREAM_DIM_WIDTH  = 8;

endpackage

// File: rtl/mstream_tx_oreg.sv
// mstream_tx_oreg: one-element output register slice carrying data and row/matrix markers
// Optional even-parity output is built when MSTREAM_TX_PARITY_EN is defined.
module mstream_tx_oreg #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  sys_clk,
    input  logic                  reset_n,
    input  logic                  load_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  row_last_i,
    input  logic                  mat_last_i,
    input  logic                  rdy_i,
    output logic                  vld_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  row_last_o,
    output logic                  mat_last_o
`ifdef MSTREAM_TX_PARITY_EN
    ,
    output logic                  parity_o
`endif
);

    logic                  vld_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  row_last_q;
    logic                  mat_last_q;

    // Capture a new element on load; otherwise drop valid once the consumer takes it
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_q      <= 1'b0;
            data_q     <= '0;
            row_last_q <= 1'b0;
            mat_last_q <= 1'b0;
        end else if (load_i) begin
            vld_q      <= 1'b1;
            data_q     <= data_i;
            row_last_q <= row_last_i;
            mat_last_q <= mat_last_i;
        end else if (rdy_i) begin
            vld_q      <= 1'b0;
        end
    end

    assign vld_o      = vld_q;
    assign data_o     = data_q;
    assign row_last_o = row_last_q;
    assign mat_last_o = mat_last_q;

`ifdef MSTREAM_TX_PARITY_EN
    logic parity_q;

    // Parity is loaded together with the data so it holds under backpressure as well
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            parity_q <= 1'b0;
        end else if (load_i) begin
            parity_q <= ^data_i;
        end
    end

    assign parity_o = parity_q;
`endif

endmodule

// File: rtl/mstream_tx.sv
// mstream_tx: streams a rows x cols matrix received element-wise in row-major order,
// tagging the last column of each row and the last element of the matrix.
// Define MSTREAM_TX_PARITY_EN to add the tx_parity output.
module mstream_tx
    import mstream_pkg::*;
#(
    parameter int DATA_WIDTH = MSTREAM_DATA_WIDTH,
    parameter int DIM_WIDTH  = MSTREAM_DIM_WIDTH
) (
    input  logic                  sys_clk,
    input  logic                  reset_n,
    input  logic                  cmd_vld,
    output logic                  cmd_rdy,
    input  logic [DIM_WIDTH-1:0]  cmd_rows,
    input  logic [DIM_WIDTH-1:0]  cmd_cols,
    input  logic                  in_vld,
    output logic                  in_rdy,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  tx_vld,
    input  logic                  tx_rdy,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_row_last,
    output logic                  tx_mat_last,
    output logic                  cmd_err,
    output logic                  busy
`ifdef MSTREAM_TX_PARITY_EN
    ,
    output logic                  tx_parity
`endif
);

    localparam logic [DIM_WIDTH-1:0] DIM_ONE = 1;

    state_e               state_q;
    logic [DIM_WIDTH-1:0] rows_q;
    logic [DIM_WIDTH-1:0] cols_q;
    logic [DIM_WIDTH-1:0] row_cnt_q;
    logic [DIM_WIDTH-1:0] col_cnt_q;
    logic                 cmd_err_q;
    logic                 cmd_hs;
    logic                 cmd_zero;
    logic                 in_hs;
    logic                 row_last;
    logic                 mat_last;

    // A new command waits until the last element of the previous matrix has left
    assign cmd_rdy  = (state_q == IDLE) && !tx_vld;
    assign in_rdy   = (state_q == STREAM) && (!tx_vld || tx_rdy);
    assign cmd_hs   = cmd_vld && cmd_rdy;
    assign cmd_zero = (cmd_rows == '0) || (cmd_cols == '0);
    assign in_hs    = in_vld && in_rdy;
    assign row_last = col_cnt_q == cols_q - DIM_ONE;
    assign mat_last = row_last && (row_cnt_q == rows_q - DIM_ONE);
    assign cmd_err  = cmd_err_q;
    assign busy     = (state_q != IDLE) || tx_vld;

    // Command acceptance, row-major position walk and return to IDLE on the final element
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            rows_q    <= '0;
            cols_q    <= '0;
            row_cnt_q <= '0;
            col_cnt_q <= '0;
            cmd_err_q <= 1'b0;
        end else begin
            cmd_err_q <= cmd_hs && cmd_zero;
            case (state_q)
                IDLE: begin
                    if (cmd_hs && !cmd_zero) begin
                        state_q   <= STREAM;
                        rows_q    <= cmd_rows;
                        cols_q    <= cmd_cols;
                        row_cnt_q <= '0;
                        col_cnt_q <= '0;
                    end
                end
                STREAM: begin
                    if (in_hs) begin
                        col_cnt_q <= row_last ? '0 : col_cnt_q + DIM_ONE;
                        row_cnt_q <= row_last ? row_cnt_q + DIM_ONE : row_cnt_q;
                        if (mat_last) begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    mstream_tx_oreg #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_oreg (
        .sys_clk    (sys_clk),
        .reset_n    (reset_n),
        .load_i     (in_hs),
        .data_i     (in_data),
        .row_last_i (row_last),
        .mat_last_i (mat_last),
        .rdy_i      (tx_rdy),
        .vld_o      (tx_vld),
        .data_o     (tx_data),
        .row_last_o (tx_row_last),
        .mat_last_o (tx_mat_last)
`ifdef MSTREAM_TX_PARITY_EN
        ,
        .parity_o   (tx_parity)
`endif
    );

endmodule

// File: tb/tb_mstream_tx.sv
// tb_mstream_tx: randomized bench for mstream_tx against a queue-based matrix model
module tb_mstream_tx;

    localparam int DW = 32;
    localparam int MW = 8;

    logic          sys_clk  = 1'b0;
    logic          reset_n  = 1'b0;
    logic          cmd_vld  = 1'b0;
    logic          cmd_rdy;
    logic [MW-1:0] cmd_rows = '0;
    logic [MW-1:0] cmd_cols = '0;
    logic          in_vld   = 1'b0;
    logic          in_rdy;
    logic [DW-1:0] in_data  = '0;
    logic          tx_vld;
    logic          tx_rdy   = 1'b0;
    logic [DW-1:0] tx_data;
    logic          tx_row_last;
    logic          tx_mat_last;
    logic          cmd_err;
    logic          busy;
`ifdef MSTREAM_TX_PARITY_EN
    logic          tx_parity;
`endif

    typedef struct {
        logic [DW-1:0] data;
        logic          rl;
        logic          ml;
    } elem_t;

    elem_t         expq[$];
    int            n_chk = 0;
    int            n_pass = 0;
    bit            active = 0;
    int            k = 0;
    int            m_rows = 0;
    int            m_cols = 0;
    bit            err_exp = 0;
    int            cyc = 0;
    int            ntx = 0;
    int            n_rl = 0;
    int            n_ml = 0;
    int            n_err = 0;
    int            n_stall = 0;
    int            n_txv = 0;
    int            first_cyc = -1;
    int            last_cyc = 0;
    int            rdy_pct = 100;
    int            stall_n = 0;
    logic [DW-1:0] stall_at = '0;
    bit            prev_stall = 0;
    logic [DW-1:0] prev_data = '0;

    mstream_tx dut (
        .sys_clk     (sys_clk),
        .reset_n     (reset_n),
        .cmd_vld     (cmd_vld),
        .cmd_rdy     (cmd_rdy),
        .cmd_rows    (cmd_rows),
        .cmd_cols    (cmd_cols),
        .in_vld      (in_vld),
        .in_rdy      (in_rdy),
        .in_data     (in_data),
        .tx_vld      (tx_vld),
        .tx_rdy      (tx_rdy),
        .tx_data     (tx_data),
        .tx_row_last (tx_row_last),
        .tx_mat_last (tx_mat_last),
        .cmd_err     (cmd_err),
        .busy        (busy)
`ifdef MSTREAM_TX_PARITY_EN
        ,
        .tx_parity   (tx_parity)
`endif
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic clr();
        ntx = 0; n_rl = 0; n_ml = 0; n_err = 0; n_stall = 0; n_txv = 0;
        first_cyc = -1; last_cyc = 0;
    endtask

    task automatic idle(int n);
        repeat (n) begin
            @(posedge sys_clk); #1;
        end
    endtask

    task automatic send_cmd(int r, int c);
        bit hs;
        cmd_vld = 1'b1; cmd_rows = MW'(r); cmd_cols = MW'(c);
        for (int t = 0; t < 200; t++) begin
            @(negedge sys_clk); hs = cmd_rdy;
            @(posedge sys_clk); #1;
            if (hs) break;
            if (t == 199) check("cmd_timeout", 64'(cmd_rdy), 64'd1);
        end
        cmd_vld = 1'b0;
    endtask

    task automatic feed(int n, int vld_pct, bit seq, logic [DW-1:0] base);
        int i = 0;
        int t = 0;
        bit acc;
        while (i < n) begin
            in_vld  = ($urandom_range(99) < vld_pct);
            in_data = seq ? base + DW'(i) : DW'($urandom);
            @(negedge sys_clk); acc = in_vld && in_rdy;
            @(posedge sys_clk); #1;
            if (acc) begin
                i++; t = 0;
            end else if (++t > 1000) begin
                check("in_timeout", 64'(i), 64'(n));
                break;
            end
        end
        in_vld = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((tx_vld || expq.size() != 0) && t < 2000) begin
            @(posedge sys_clk); #1; t++;
        end
        check("drain", 64'(tx_vld), 64'd0);
    endtask

    // Downstream ready: random, with an optional forced stall on a chosen element value
    initial forever begin
        @(posedge sys_clk); #1;
        if (stall_n > 0 && tx_vld && tx_data == stall_at) begin
            tx_rdy = 1'b0; stall_n--;
        end else begin
            tx_rdy = ($urandom_range(99) < rdy_pct);
        end
    end

    // Reference model: each accepted input at row-major index k becomes one expected output
    initial begin
        elem_t e;
        forever begin
            @(negedge sys_clk);
            cyc++;
            if (!reset_n) begin
                expq.delete(); active = 0; err_exp = 0; prev_stall = 0;
            end else begin
                check("cmd_rdy", 64'(cmd_rdy), 64'(!active && !tx_vld));
                check("in_rdy", 64'(in_rdy), 64'(active && (!tx_vld || tx_rdy)));
                check("busy", 64'(busy), 64'(active || tx_vld));
                check("cmd_err", 64'(cmd_err), 64'(err_exp));
                if (prev_stall) check("hold_data", 64'(tx_data), 64'(prev_data));
                if (tx_vld) begin
                    n_txv++;
                    check("tx_queued", 64'(expq.size() > 0), 64'd1);
                    if (expq.size() > 0) begin
                        check("tx_data", 64'(tx_data), 64'(expq[0].data));
                        check("row_last", 64'(tx_row_last), 64'(expq[0].rl));
                        check("mat_last", 64'(tx_mat_last), 64'(expq[0].ml));
`ifdef MSTREAM_TX_PARITY_EN
                        check("tx_parity", 64'(tx_parity), 64'(^expq[0].data));
`endif
                    end
                    if (tx_rdy) begin
                        if (expq.size() > 0) void'(expq.pop_front());
                        ntx++;
                        n_rl += int'(tx_row_last);
                        n_ml += int'(tx_mat_last);
                        if (first_cyc < 0) first_cyc = cyc;
                        last_cyc = cyc;
                    end else begin
                        n_stall++;
                    end
                end
                prev_stall = tx_vld && !tx_rdy;
                prev_data  = tx_data;
                n_err += int'(cmd_err);
                err_exp = cmd_vld && cmd_rdy && (cmd_rows == 0 || cmd_cols == 0);
                if (cmd_vld && cmd_rdy && cmd_rows != 0 && cmd_cols != 0) begin
                    active = 1; k = 0; m_rows = int'(cmd_rows); m_cols = int'(cmd_cols);
                end
                if (in_vld && in_rdy) begin
                    e.data = in_data;
                    e.rl   = (k % m_cols) == m_cols - 1;
                    e.ml   = k == m_rows * m_cols - 1;
                    expq.push_back(e);
                    k++;
                    if (k == m_rows * m_cols) active = 0;
                end
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge sys_clk);
        #1;
        check("rst_tx_vld", 64'(tx_vld), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_cmd_err", 64'(cmd_err), 64'd0);
        reset_n = 1'b1;
        @(negedge sys_clk);
        check("rel_cmd_rdy", 64'(cmd_rdy), 64'd1);
        check("rel_in_rdy", 64'(in_rdy), 64'd0);
        @(posedge sys_clk); #1;

        // 2x3 at full throughput
        clr(); rdy_pct = 100;
        send_cmd(2, 3);
        feed(6, 100, 1, 32'd1);
        drain();
        check("t1_count", 64'(ntx), 64'd6);
        check("t1_row_last", 64'(n_rl), 64'd2);
        check("t1_mat_last", 64'(n_ml), 64'd1);
        check("t1_consec", 64'(last_cyc - first_cyc), 64'd5);
        check("t1_cmd_rdy", 64'(cmd_rdy), 64'd1);

        // 2x2 with a three-cycle stall on element 2
        clr(); stall_at = 32'd2; stall_n = 3;
        send_cmd(2, 2);
        feed(4, 100, 1, 32'd1);
        drain();
        check("t2_count", 64'(ntx), 64'd4);
        check("t2_stall", 64'(n_stall), 64'd3);
        check("t2_mat_last", 64'(n_ml), 64'd1);

        // zero-dimension command
        clr();
        send_cmd(0, 5);
        in_vld = 1'b1;
        idle(4);
        in_vld = 1'b0;
        check("t3_err_pulses", 64'(n_err), 64'd1);
        check("t3_tx_vld_cycles", 64'(n_txv), 64'd0);
        check("t3_cmd_rdy", 64'(cmd_rdy), 64'd1);

        // 1x1 single element
        clr();
        send_cmd(1, 1);
        feed(1, 100, 1, 32'hA5);
        drain();
        check("t4_count", 64'(ntx), 64'd1);
        check("t4_row_last", 64'(n_rl), 64'd1);
        check("t4_mat_last", 64'(n_ml), 64'd1);

        // reset in the middle of a 4x4 matrix
        clr();
        send_cmd(4, 4);
        feed(5, 100, 1, 32'h100);
        #2 reset_n = 1'b0;
        #1;
        check("t5_tx_vld", 64'(tx_vld), 64'd0);
        check("t5_tx_data", 64'(tx_data), 64'd0);
        check("t5_row_last", 64'(tx_row_last), 64'd0);
        check("t5_mat_last", 64'(tx_mat_last), 64'd0);
        check("t5_busy", 64'(busy), 64'd0);
        check("t5_in_rdy", 64'(in_rdy), 64'd0);
        idle(2);
        reset_n = 1'b1;
        @(negedge sys_clk);
        check("t5_rel_cmd_rdy", 64'(cmd_rdy), 64'd1);
        check("t5_rel_tx_vld", 64'(tx_vld), 64'd0);
        @(posedge sys_clk); #1;
        clr();
        send_cmd(1, 2);
        feed(2, 100, 1, 32'h10);
        drain();
        check("t5_count", 64'(ntx), 64'd2);
        check("t5_after_rl", 64'(n_rl), 64'd1);
        check("t5_after_ml", 64'(n_ml), 64'd1);

        // random small matrices with random valid and ready
        rdy_pct = 60;
        for (int i = 0; i < 6; i++) begin
            int r;
            int c;
            r = int'($urandom_range(5, 1));
            c = int'($urandom_range(5, 1));
            clr();
            send_cmd(r, c);
            feed(r * c, 70, 0, '0);
            drain();
            check("rnd_count", 64'(ntx), 64'(r * c));
            check("rnd_row_last", 64'(n_rl), 64'(r));
            check("rnd_mat_last", 64'(n_ml), 64'd1);
        end

        // maximum dimensions
        clr(); rdy_pct = 94;
        send_cmd(255, 255);
        feed(65025, 100, 0, '0);
        drain();
        check("max_count", 64'(ntx), 64'd65025);
        check("max_row_last", 64'(n_rl), 64'd255);
        check("max_mat_last", 64'(n_ml), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
